// File: rtl/pll_lock_monitor.sv
// PLL lock supervisor: holds downstream logic in reset until the PLL lock has been
// stable long enough, re-pulses the PLL reset on timeout and counts lock losses.
module pll_lock_monitor #(
   parameter int LOCK_STABLE_CYCLES  = 4096,
   parameter int LOCK_TIMEOUT_CYCLES = 1000000,
   parameter int PLL_RST_CYCLES      = 16,
   parameter int CNT_W               = 8
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             locked_i,
   output logic             pll_rst_o,
   output logic             sys_rstn_o,
   output logic             ready_o,
   output logic             lost_pulse_o,
   output logic [CNT_W-1:0] lost_count_o
);

   localparam int MAX_AB  = (LOCK_STABLE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                            LOCK_STABLE_CYCLES : LOCK_TIMEOUT_CYCLES;
   localparam int MAX_CYC = (MAX_AB > PLL_RST_CYCLES) ? MAX_AB : PLL_RST_CYCLES;
   localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [TW-1:0]    RST_LAST    = TW'(PLL_RST_CYCLES - 1);
   localparam logic [TW-1:0]    TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0]    STABLE_LAST = TW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOST_MAX    = '1;

   typedef enum logic [1:0] {
      ST_PLL_RST,
      ST_WAIT_LOCK,
      ST_STABLE,
      ST_RUN
   } state_t;

   state_t          state_reg, state_next;
   logic [TW-1:0]   cnt_reg, cnt_next;
   logic            sync1_reg, locked_s;
   logic            lost_pulse_next;

   // locked_i is asynchronous and glitchy; only locked_s is used downstream
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sync1_reg <= 1'b0;
         locked_s  <= 1'b0;
      end else begin
         sync1_reg <= locked_i;
         locked_s  <= sync1_reg;
      end
   end

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg + 1'b1;
      lost_pulse_next = 1'b0;
      case (state_reg)
         ST_PLL_RST: begin
            if (cnt_reg == RST_LAST) begin
               state_next = ST_WAIT_LOCK;
               cnt_next   = '0;
            end
         end
         ST_WAIT_LOCK: begin
            // lock takes priority over a coincident timeout
            if (locked_s) begin
               state_next = ST_STABLE;
               cnt_next   = '0;
            end else if (cnt_reg == TIMEOUT_LAST) begin
               state_next = ST_PLL_RST;
               cnt_next   = '0;
            end
         end
         ST_STABLE: begin
            if (!locked_s) begin
               state_next = ST_WAIT_LOCK;
               cnt_next   = '0;
            end else if (cnt_reg == STABLE_LAST) begin
               state_next = ST_RUN;
               cnt_next   = '0;
            end
         end
         ST_RUN: begin
            cnt_next = '0;
            if (!locked_s) begin
               state_next      = ST_WAIT_LOCK;
               lost_pulse_next = 1'b1;
            end
         end
         default: begin
            state_next = ST_PLL_RST;
            cnt_next   = '0;
         end
      endcase
   end

   // Outputs are decoded from state_next so they change on the same edge as the state
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_reg    <= ST_PLL_RST;
         cnt_reg      <= '0;
         pll_rst_o    <= 1'b1;
         sys_rstn_o   <= 1'b0;
         ready_o      <= 1'b0;
         lost_pulse_o <= 1'b0;
         lost_count_o <= '0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         pll_rst_o    <= (state_next == ST_PLL_RST);
         sys_rstn_o   <= (state_next == ST_RUN);
         ready_o      <= (state_next == ST_RUN);
         lost_pulse_o <= lost_pulse_next;
         if (lost_pulse_next && (lost_count_o != LOST_MAX)) begin
            lost_count_o <= lost_count_o + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Scoreboard bench for pll_lock_monitor: stimulus pushes cycle-tagged expected output
// vectors, a negedge monitor pops and compares them.
module tb_pll_lock_monitor;

   localparam int STB = 8;
   localparam int TO  = 32;
   localparam int PR  = 4;
   localparam int CW  = 2;

   logic          clk = 1'b0;
   logic          rstn;
   logic          locked;
   logic          pll_rst;
   logic          sys_rstn;
   logic          ready;
   logic          lost_pulse;
   logic [CW-1:0] lost_count;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int         cyc;
      logic [5:0] vec;
      string      name;
   } exp_t;

   exp_t sb_q[$];

   pll_lock_monitor #(
      .LOCK_STABLE_CYCLES (STB),
      .LOCK_TIMEOUT_CYCLES(TO),
      .PLL_RST_CYCLES     (PR),
      .CNT_W              (CW)
   ) dut (
      .clk_i       (clk),
      .rstn_i      (rstn),
      .locked_i    (locked),
      .pll_rst_o   (pll_rst),
      .sys_rstn_o  (sys_rstn),
      .ready_o     (ready),
      .lost_pulse_o(lost_pulse),
      .lost_count_o(lost_count)
   );

   always #5 clk = ~clk;

   // cyc = number of rising edges seen so far
   always @(posedge clk) cyc <= cyc + 1;

   // vector layout: {pll_rst, sys_rstn, ready, lost_pulse, lost_count}
   function automatic logic [5:0] mk(input logic p, input logic s, input logic r,
                                     input logic l, input logic [1:0] c);
      return {p, s, r, l, c};
   endfunction

   task automatic push(input int c, input logic [5:0] v, input string n);
      exp_t e;
      e.cyc  = c;
      e.vec  = v;
      e.name = n;
      sb_q.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      exp_t       e;
      logic [5:0] act;
      forever begin
         @(negedge clk);
         act = {pll_rst, sys_rstn, ready, lost_pulse, lost_count};
         while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            checks++;
            if (e.cyc < cyc) begin
               errors++;
               $display("FAIL %s cyc %0d: expectation reached monitor late at cyc %0d",
                        e.name, e.cyc, cyc);
            end else if (act !== e.vec) begin
               errors++;
               $display("FAIL %s cyc %0d: pll_rst/sys_rstn/ready/lost_pulse/lost_count got %b required %b",
                        e.name, e.cyc, act, e.vec);
            end else begin
               $display("check %s cyc %0d vec %b", e.name, e.cyc, act);
            end
         end
      end
   end

   // Drop lock in RUN, relock (optionally with a 2-cycle glitch during STABLE) and
   // expect every cycle from the drop until two cycles into the new RUN.
   task automatic loss_relock(input logic [1:0] prev, input bit glitch, input string n);
      int         l, rn;
      logic [1:0] nc;
      nc = (prev == 2'd3) ? 2'd3 : prev + 2'd1;
      tick(1);
      l      = cyc;
      locked = 1'b0;
      rn     = glitch ? l + 25 : l + 15;
      for (int c = l; c <= l + 2; c++) push(c, mk(0, 1, 1, 0, prev), {n, "_still_run"});
      push(l + 3, mk(0, 0, 0, 1, nc), {n, "_lost"});
      for (int c = l + 4; c < rn; c++) push(c, mk(0, 0, 0, 0, nc), {n, "_relocking"});
      push(rn, mk(0, 1, 1, 0, nc), {n, "_run"});
      push(rn + 1, mk(0, 1, 1, 0, nc), {n, "_run"});
      tick(4);
      locked = 1'b1;
      if (glitch) begin
         tick(8);
         locked = 1'b0;
         tick(2);
         locked = 1'b1;
      end
      tick(rn + 1 - cyc);
   endtask

   initial begin
      int r, k, r2;
      rstn   = 1'b0;
      locked = 1'b0;
      tick(2);
      push(cyc, mk(1, 0, 0, 0, 2'd0), "reset_hold");
      tick(1);
      push(cyc, mk(1, 0, 0, 0, 2'd0), "reset_hold");

      // no lock: 4 cycles of PLL reset, 32 cycles waiting, repeating
      r    = cyc;
      rstn = 1'b1;
      for (int c = 0; c <= 75; c++) push(r + c, mk((c % 36) < 4, 0, 0, 0, 2'd0), "timeout_cycle");
      tick(80);

      // lock raised inside WAIT_LOCK: RUN after edge k+11
      k      = cyc;
      locked = 1'b1;
      for (int c = 0; c <= 10; c++) push(k + c, mk(0, 0, 0, 0, 2'd0), "lock_wait");
      push(k + 11, mk(0, 1, 1, 0, 2'd0), "lock_run");
      push(k + 12, mk(0, 1, 1, 0, 2'd0), "lock_run");
      tick(12);

      loss_relock(2'd0, 1'b0, "loss1");
      loss_relock(2'd1, 1'b1, "loss2_glitch");

      // asynchronous reset in RUN, applied between clock edges
      tick(1);
      #1;
      rstn = 1'b0;
      push(cyc, mk(1, 0, 0, 0, 2'd0), "async_reset");
      tick(1);
      push(cyc, mk(1, 0, 0, 0, 2'd0), "async_reset_hold");
      tick(1);
      r2   = cyc;
      rstn = 1'b1;
      // lock already present: still a full PLL reset pulse before it is accepted
      for (int c = 0; c <= 3; c++) push(r2 + c, mk(1, 0, 0, 0, 2'd0), "rerun_pll_rst");
      for (int c = 4; c <= 12; c++) push(r2 + c, mk(0, 0, 0, 0, 2'd0), "rerun_stable");
      push(r2 + 13, mk(0, 1, 1, 0, 2'd0), "rerun_run");
      push(r2 + 14, mk(0, 1, 1, 0, 2'd0), "rerun_run");
      tick(14);

      loss_relock(2'd0, 1'b0, "sat1");
      loss_relock(2'd1, 1'b0, "sat2");
      loss_relock(2'd2, 1'b0, "sat3");
      loss_relock(2'd3, 1'b0, "sat4");

      tick(2);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
